// File: rtl/vid_timing_gen_pkg.sv
// Shared types and constants for the video timing generator.
// Pattern encodings, colour-bar table, FSM states and the registered output payload.
package vid_timing_gen_pkg;

  localparam int unsigned H_CNT_W = 12;
  localparam int unsigned V_CNT_W = 11;
  localparam int unsigned PIX_W   = 24;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_GREY  = 2'd2,
    PAT_COORD = 2'd3
  } pat_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [PIX_W-1:0] GREY_PIX = 24'h808080;

  // Index 0 (white) sits in the least-significant slot
  localparam logic [7:0][PIX_W-1:0] BAR_RGB = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  typedef struct packed {
    logic             vsync;
    logic             hsync;
    logic             de;
    logic [PIX_W-1:0] data;
    logic             frame_start;
  } vid_out_t;

endpackage

// File: rtl/vid_pattern_gen.sv
// Combinational test-pattern pixel for the current raster position.
// With VTG_COORD_EMBED_EN defined, pattern 3 carries a per-frame-moving box coordinate.
module vid_pattern_gen
  import vid_timing_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1920,
  parameter int unsigned V_ACTIVE = 1080
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               advance,
  input  pat_e               pat,
  input  logic [H_CNT_W-1:0] h_cnt,
  input  logic [V_CNT_W-1:0] v_cnt,
  output logic [PIX_W-1:0]   pixel_c
);

  localparam int unsigned BAR_CMP_W = H_CNT_W + 3;

  logic [BAR_CMP_W-1:0] h_x8;
  logic [2:0]           bar_idx;
  logic [PIX_W-1:0]     coord_pix;
  logic                 unused_v;

  assign h_x8     = {h_cnt, 3'b000};
  assign unused_v = ^v_cnt[V_CNT_W-1:8];

  // Bar index = h*8/H_ACTIVE, resolved by threshold compares instead of a divider
  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (h_x8 >= BAR_CMP_W'(k * H_ACTIVE)) bar_idx = 3'(k);
    end
  end

`ifdef VTG_COORD_EMBED_EN
  localparam logic [H_CNT_W-1:0] BOX_X_MAX = H_CNT_W'(H_ACTIVE - 48);
  localparam logic [V_CNT_W-1:0] BOX_Y_MAX = V_CNT_W'(V_ACTIVE - 48);

  logic [10:0]        box_x;
  logic [9:0]         box_y;
  logic [H_CNT_W-1:0] box_x_nxt;
  logic [V_CNT_W-1:0] box_y_nxt;

  assign box_x_nxt = H_CNT_W'(box_x) + H_CNT_W'(4);
  assign box_y_nxt = V_CNT_W'(box_y) + V_CNT_W'(2);

  // Box steps once per completed frame and restarts when it would leave the window
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      box_x <= '0;
      box_y <= '0;
    end else if (advance) begin
      box_x <= (box_x_nxt > BOX_X_MAX) ? '0 : box_x_nxt[10:0];
      box_y <= (box_y_nxt > BOX_Y_MAX) ? '0 : box_y_nxt[9:0];
    end
  end

  assign coord_pix = {3'b000, box_y, box_x};
`else
  logic unused_box;

  assign unused_box = ^{clk, rstn, advance};
  assign coord_pix  = GREY_PIX;
`endif

  always_comb begin
    pixel_c = GREY_PIX;
    case (pat)
      PAT_BARS:  pixel_c = BAR_RGB[bar_idx];
      PAT_RAMP:  pixel_c = {h_cnt[7:0], v_cnt[7:0], h_cnt[7:0] ^ v_cnt[7:0]};
      PAT_GREY:  pixel_c = GREY_PIX;
      PAT_COORD: pixel_c = coord_pix;
      default:   pixel_c = GREY_PIX;
    endcase
  end

endmodule

// File: rtl/vid_timing_gen.sv
// Programmable raster timing source with selectable test pattern.
// Optional coordinate embedding in pattern 3 is enabled by VTG_COORD_EMBED_EN.
module vid_timing_gen
  import vid_timing_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1920,
  parameter int unsigned H_FP     = 88,
  parameter int unsigned H_SYNC   = 44,
  parameter int unsigned H_BP     = 148,
  parameter int unsigned V_ACTIVE = 1080,
  parameter int unsigned V_FP     = 4,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 36,
  parameter bit          SYNC_POL = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [1:0]       pattern,
  output logic             vsync,
  output logic             hsync,
  output logic             de,
  output logic [PIX_W-1:0] data,
  output logic             frame_start,
  output logic             busy
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL >= 4096) begin : g_h_total_chk
    $error("H_TOTAL does not fit the 12-bit horizontal counter");
  end
  if (V_TOTAL >= 2048) begin : g_v_total_chk
    $error("V_TOTAL does not fit the 11-bit vertical counter");
  end

  localparam logic [H_CNT_W-1:0] H_LAST   = H_CNT_W'(H_TOTAL - 1);
  localparam logic [H_CNT_W-1:0] H_ACT_E  = H_CNT_W'(H_ACTIVE);
  localparam logic [H_CNT_W-1:0] HS_BEG   = H_CNT_W'(H_ACTIVE + H_FP);
  localparam logic [H_CNT_W-1:0] HS_END   = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_CNT_W-1:0] V_LAST   = V_CNT_W'(V_TOTAL - 1);
  localparam logic [V_CNT_W-1:0] V_ACT_E  = V_CNT_W'(V_ACTIVE);
  localparam logic [V_CNT_W-1:0] VS_BEG   = V_CNT_W'(V_ACTIVE + V_FP);
  localparam logic [V_CNT_W-1:0] VS_END   = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam vid_out_t OUT_IDLE = '{
    vsync: !SYNC_POL, hsync: !SYNC_POL, de: 1'b0, data: '0, frame_start: 1'b0
  };

  state_e             state_q, state_d;
  logic [H_CNT_W-1:0] h_q, h_d;
  logic [V_CNT_W-1:0] v_q, v_d;
  pat_e               pat_q, pat_cur_c;
  vid_out_t           out_q, out_d;
  logic               busy_q;
  logic               run_c, first_px_c, frame_end_c, line_end_c;
  logic               de_c, hs_act_c, vs_act_c;
  logic [PIX_W-1:0]   pixel_c;

  assign run_c       = (state_q == ST_RUN);
  assign line_end_c  = (h_q == H_LAST);
  assign frame_end_c = line_end_c && (v_q == V_LAST);
  assign first_px_c  = run_c && (h_q == '0) && (v_q == '0);
  assign de_c        = (h_q < H_ACT_E) && (v_q < V_ACT_E);
  assign hs_act_c    = (h_q >= HS_BEG) && (h_q < HS_END);
  assign vs_act_c    = (v_q >= VS_BEG) && (v_q < VS_END);

  // Pattern is captured on the first pixel and held for the rest of the frame
  assign pat_cur_c = first_px_c ? pat_e'(pattern) : pat_q;

  vid_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_pattern (
    .clk     (clk),
    .rstn    (rstn),
    .advance (run_c && frame_end_c),
    .pat     (pat_cur_c),
    .h_cnt   (h_q),
    .v_cnt   (v_q),
    .pixel_c (pixel_c)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      v_q     <= '0;
      pat_q   <= PAT_BARS;
      out_q   <= OUT_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      pat_q   <= pat_cur_c;
      out_q   <= out_d;
      busy_q  <= (state_d == ST_RUN);
    end
  end

  // Stop requests are only honoured on the last pixel of a frame
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    out_d   = OUT_IDLE;
    case (state_q)
      ST_IDLE: begin
        h_d = '0;
        v_d = '0;
        if (en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (line_end_c) begin
          h_d = '0;
          v_d = frame_end_c ? '0 : v_q + V_CNT_W'(1);
        end else begin
          h_d = h_q + H_CNT_W'(1);
        end
        if (frame_end_c && !en) state_d = ST_IDLE;
        out_d.de          = de_c;
        out_d.hsync       = hs_act_c ? SYNC_POL : !SYNC_POL;
        out_d.vsync       = vs_act_c ? SYNC_POL : !SYNC_POL;
        out_d.data        = de_c ? pixel_c : '0;
        out_d.frame_start = first_px_c;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign vsync       = out_q.vsync;
  assign hsync       = out_q.hsync;
  assign de          = out_q.de;
  assign data        = out_q.data;
  assign frame_start = out_q.frame_start;
  assign busy        = busy_q;

endmodule

// File: tb/tb_vid_timing_gen.sv
// Randomized scoreboard bench for vid_timing_gen against a frame-position reference model.
`timescale 1ns/1ps
module tb_vid_timing_gen;

`ifdef VTG_COORD_EMBED_EN
  localparam int HA = 64;
  localparam int VA = 52;
`else
  localparam int HA = 16;
  localparam int VA = 8;
`endif
  localparam int HFP = 2, HSW = 2, HBP = 2;
  localparam int VFP = 1, VSW = 1, VBP = 1;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam bit POL = 1'b1;
  localparam int BOUND = 2 * FRAME + 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  pattern = 2'd0;
  logic        vsync, hsync, de, frame_start, busy;
  logic [23:0] data;

  vid_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .SYNC_POL(POL)
  ) dut (
    .clk(clk), .rstn(rstn), .en(en), .pattern(pattern),
    .vsync(vsync), .hsync(hsync), .de(de), .data(data),
    .frame_start(frame_start), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        vs;
    logic        hs;
    logic        de;
    logic [23:0] data;
    logic        fs;
    logic        busy;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference state: whether a frame is running and the linear pixel index inside it
  bit   m_run = 1'b0;
  int   m_pos = 0;
  int   m_pat = 0;
  int   box_x = 0;
  int   box_y = 0;
  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  function automatic logic [23:0] ref_pixel(input int pat, input int h, input int v);
    logic [7:0] hb, vb;
    hb = 8'(h);
    vb = 8'(v);
    case (pat)
      0: return bar_tab[(h * 8) / HA];
      1: return {hb, vb, hb ^ vb};
`ifdef VTG_COORD_EMBED_EN
      3: return {3'b000, 10'(box_y), 11'(box_x)};
`endif
      default: return 24'h808080;
    endcase
  endfunction

  function automatic obs_t idle_obs();
    obs_t o;
    o.vs = !POL; o.hs = !POL; o.de = 1'b0; o.data = '0; o.fs = 1'b0; o.busy = 1'b0;
    return o;
  endfunction

  task automatic model_step();
    obs_t e;
    int h, v, p;
    e = idle_obs();
    if (m_run) begin
      h = m_pos % HT;
      v = m_pos / HT;
      p = (m_pos == 0) ? int'(pattern) : m_pat;
      e.de   = (h < HA) && (v < VA);
      e.hs   = (h >= HA + HFP && h < HA + HFP + HSW) ? POL : !POL;
      e.vs   = (v >= VA + VFP && v < VA + VFP + VSW) ? POL : !POL;
      e.data = e.de ? ref_pixel(p, h, v) : 24'h0;
      e.fs   = (m_pos == 0);
      m_pat  = p;
      if (m_pos == FRAME - 1) begin
        box_x = (box_x + 4 > HA - 48) ? 0 : box_x + 4;
        box_y = (box_y + 2 > VA - 48) ? 0 : box_y + 2;
        m_pos = 0;
        if (!en) m_run = 1'b0;
      end else begin
        m_pos++;
      end
    end else if (en) begin
      m_run = 1'b1;
      m_pos = 0;
    end
    e.busy = m_run;
    exp_q.push_back(e);
  endtask

  // Expectation producer: one entry per clock, flushed to reset values on reset
  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      m_run = 1'b0; m_pos = 0; m_pat = 0; box_x = 0; box_y = 0;
      exp_q.delete();
      exp_q.push_back(idle_obs());
    end else begin
      model_step();
    end
  end

  // Monitor: compares DUT outputs mid-cycle against the oldest expectation
  initial forever begin
    obs_t e, a;
    @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL no_expectation t=%0t", $time);
    end else begin
      e = exp_q.pop_front();
      a = '{vs: vsync, hs: hsync, de: de, data: data, fs: frame_start, busy: busy};
      if (a !== e) begin
        n_fail++;
        $display("FAIL output t=%0t got vs=%b hs=%b de=%b data=%h fs=%b busy=%b required vs=%b hs=%b de=%b data=%h fs=%b busy=%b",
                 $time, a.vs, a.hs, a.de, a.data, a.fs, a.busy, e.vs, e.hs, e.de, e.data, e.fs, e.busy);
      end
    end
  end

  task automatic check(input string name, input int got, input int req);
    n_checks++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_fs(output int cycles);
    cycles = 0;
    while (!frame_start && cycles < BOUND) begin
      tick(1);
      cycles++;
    end
  endtask

  initial begin
    #(20 * 100000);
    $display("FAIL watchdog expired t=%0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tick(3);
    rstn = 1'b1;
    tick(4);

    // Random run with pattern changes and en toggles
    en = 1'b1;
    pattern = 2'd1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick(1);
      if ($urandom_range(0, FRAME / 3) == 0) pattern = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) en = ~en;
    end

    // Continuous run with pattern 3; also frame period
    en = 1'b1;
    pattern = 2'd3;
    wait_fs(n);
    tick(1);
    wait_fs(n);
    check("frame_start_period", n + 1, FRAME);
    tick(5 * FRAME);

    // Drain to idle, then a one-cycle en pulse runs exactly one frame
    en = 1'b0;
    pattern = 2'($urandom_range(0, 3));
    n = 0;
    while (busy && n < BOUND) begin
      tick(1);
      n++;
    end
    check("drained_to_idle", int'(busy), 0);
    tick(3);
    en = 1'b1;
    tick(1);
    en = 1'b0;
    check("busy_after_pulse", int'(busy), 1);
    n = 0;
    while (busy && n < BOUND) begin
      tick(1);
      n++;
    end
    check("busy_length", n, FRAME);
    tick(10);
    check("idle_de", int'(de), 0);

    // Ramp, then switch to grey mid-frame, then reset mid-line
    en = 1'b1;
    pattern = 2'd1;
    wait_fs(n);
    tick(HT + 3);
    pattern = 2'd2;
    tick(1);
    wait_fs(n);
    tick(2 * HT + 5);
    rstn = 1'b0;
    #1;
    check("rst_de", int'(de), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_hsync", int'(hsync), int'(!POL));
    tick(2);
    rstn = 1'b1;
    pattern = 2'd3;
    wait_fs(n);
    check("restart_latency", n, 2);
    tick(2 * FRAME);

    en = 1'b0;
    tick(FRAME + 10);
    check("final_busy", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
